// File: rtl/parking_pkg.sv
// Shared gate state encoding and default sizing for the parking gate controller.
package parking_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OPEN = 2'd1,
        HOLD = 2'd2
    } gate_state_t;

    localparam int DEF_CAPACITY = 10;
    localparam int DEF_RESERVED = 2;
    localparam int DEF_TIMEOUT  = 16;

endpackage

// File: rtl/parking_gate_controller_gate_fsm.sv
// Single-gate handshake FSM: request opens the gate next cycle, a pass or timeout closes it.
// Refused requests park in HOLD until the request drops, so a waiting car is refused only once.
module gate_fsm
    import parking_pkg::*;
#(
    parameter int TIMEOUT = DEF_TIMEOUT,
    parameter int TO_W    = 5
) (
    input  logic clk,
    input  logic rst,
    input  logic req,
    input  logic allow,
    input  logic pass,
    output logic gate_open,
    output logic pass_commit,
    output logic deny_pulse,
    output logic timeout_pulse
);

    localparam logic [TO_W-1:0] TIMER_LAST = TO_W'(TIMEOUT - 1);

    gate_state_t     state;
    gate_state_t     next_state;
    logic [TO_W-1:0] timer;
    logic            timer_done;

    assign timer_done = (timer == TIMER_LAST);

    // Timer runs only while open and restarts from zero on every opening.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state <= IDLE;
            timer <= '0;
        end else begin
            state <= next_state;
            if (state == OPEN) begin
                timer <= timer + 1'b1;
            end else begin
                timer <= '0;
            end
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (req) begin
                    next_state = allow ? OPEN : HOLD;
                end
            end
            OPEN: begin
                if (pass || timer_done) begin
                    next_state = IDLE;
                end
            end
            HOLD: begin
                if (!req) begin
                    next_state = IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    always_comb begin
        gate_open     = (state == OPEN);
        pass_commit   = (state == OPEN) && pass;
        deny_pulse    = (state == IDLE) && req && !allow;
        timeout_pulse = (state == OPEN) && timer_done && !pass;
    end

endmodule

// File: rtl/parking_gate_controller.sv
// Entry/exit gate controller with occupancy counter and permit-only reserved slots.
// Gates open one cycle after request; count moves one cycle after a confirmed pass.
module parking_gate_controller
    import parking_pkg::*;
#(
    parameter int CAPACITY = DEF_CAPACITY,
    parameter int CNT_W    = 8,
    parameter int RESERVED = DEF_RESERVED,
    parameter int TIMEOUT  = DEF_TIMEOUT,
    parameter int TO_W     = 5
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             entry_req,
    input  logic             entry_permit,
    input  logic             entry_pass,
    input  logic             exit_req,
    input  logic             exit_pass,
    output logic             entry_gate_open,
    output logic             exit_gate_open,
    output logic [CNT_W-1:0] count,
    output logic [CNT_W-1:0] spots_free,
    output logic             general_full,
    output logic             parking_full,
    output logic             entry_denied,
    output logic             timeout_err,
    output logic             underflow_err
);

    localparam logic [CNT_W-1:0] CAP_LIMIT = CNT_W'(CAPACITY);
    localparam logic [CNT_W-1:0] GEN_LIMIT = CNT_W'(CAPACITY - RESERVED);

    logic [CNT_W-1:0] count_q;
    logic             entry_allow;
    logic             entry_commit;
    logic             entry_deny;
    logic             entry_to;
    logic             exit_commit;
    logic             exit_deny;
    logic             exit_to;
    logic             inc;
    logic             dec;
    logic             underflow_nxt;

    assign count        = count_q;
    assign spots_free   = CAP_LIMIT - count_q;
    assign parking_full = (count_q >= CAP_LIMIT);
    assign general_full = (count_q >= GEN_LIMIT);

    // Permit holders may use the reserved slots; everyone else stops at the general limit.
    assign entry_allow = entry_permit ? !parking_full : !general_full;

    gate_fsm #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_entry_gate (
        .clk           (clk),
        .rst           (rst),
        .req           (entry_req),
        .allow         (entry_allow),
        .pass          (entry_pass),
        .gate_open     (entry_gate_open),
        .pass_commit   (entry_commit),
        .deny_pulse    (entry_deny),
        .timeout_pulse (entry_to)
    );

    gate_fsm #(
        .TIMEOUT (TIMEOUT),
        .TO_W    (TO_W)
    ) u_exit_gate (
        .clk           (clk),
        .rst           (rst),
        .req           (exit_req),
        .allow         (1'b1),
        .pass          (exit_pass),
        .gate_open     (exit_gate_open),
        .pass_commit   (exit_commit),
        .deny_pulse    (exit_deny),
        .timeout_pulse (exit_to)
    );

    assign inc           = entry_commit && !parking_full;
    assign dec           = exit_commit && (count_q != '0);
    assign underflow_nxt = exit_commit && (count_q == '0);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            count_q       <= '0;
            entry_denied  <= 1'b0;
            timeout_err   <= 1'b0;
            underflow_err <= 1'b0;
        end else begin
            // Simultaneous entry and exit commits cancel out.
            case ({inc, dec})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            // The exit FSM has allow tied high, so exit_deny stays low.
            entry_denied  <= entry_deny | exit_deny;
            timeout_err   <= entry_to | exit_to;
            underflow_err <= underflow_nxt;
        end
    end

endmodule
